// File: rtl/lifo_rr_arbiter_if.sv
// lifo_rr_arbiter_if: client and stack-side signal bundle for lifo_rr_arbiter.
// master = requester clients plus the stack instance; slave = the arbiter.
interface lifo_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 2
);
  localparam int ID_W = $clog2(NREQ);

  // requester side
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_op;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            req_ready;

  // stack side
  logic                       lifo_push;
  logic                       lifo_pop;
  logic [DATA_WIDTH-1:0]      lifo_din;
  logic [DATA_WIDTH-1:0]      lifo_dout;
  logic                       lifo_full;
  logic                       lifo_empty;

  // tagged response
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic                       rsp_op;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       rsp_err;

  modport master (
    output req_valid, req_op, req_wdata, lifo_dout, lifo_full, lifo_empty,
    input  req_ready, lifo_push, lifo_pop, lifo_din,
    input  rsp_valid, rsp_id, rsp_op, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_wdata, lifo_dout, lifo_full, lifo_empty,
    output req_ready, lifo_push, lifo_pop, lifo_din,
    output rsp_valid, rsp_id, rsp_op, rsp_data, rsp_err
  );
endinterface

// File: rtl/lifo_rr_arbiter.sv
// lifo_rr_arbiter: round-robin arbiter sharing one synchronous LIFO between
// NREQ requesters. At most one push/pop granted per cycle; a tagged response
// follows one cycle after every grant.
// Optional feature macro: LIFO_ARB_ERR_EN -- push-on-full / pop-on-empty are
// granted and answered with rsp_err = 1 instead of being stalled.
module lifo_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 2
) (
  input  logic              clk,
  input  logic              clr,
  lifo_rr_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NREQ);

  logic [DATA_WIDTH-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]       eligible;
  logic [NREQ-1:0]       ready_vec;

  logic                  grant;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_op;
  logic                  grant_err;
  logic                  do_push;
  logic                  do_pop;

  logic [ID_W-1:0]       rr_ptr_reg;
  logic [ID_W-1:0]       rr_ptr_next;
  logic                  rsp_valid_reg;
  logic [ID_W-1:0]       rsp_id_reg;
  logic                  rsp_op_reg;
  logic                  rsp_err_reg;

  // Per-requester data slicing, eligibility and one-hot ready decode.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef LIFO_ARB_ERR_EN
      // Every pending request competes; stack condition only decides the error flag.
      assign eligible[gi] = bus.req_valid[gi];
`else
      // A push needs room, a pop needs data; otherwise the request waits.
      assign eligible[gi] = bus.req_valid[gi] &
                            (bus.req_op[gi] ? ~bus.lifo_full : ~bus.lifo_empty);
`endif
      assign ready_vec[gi] = grant & (grant_id == ID_W'(gi));
    end
  endgenerate

  // Scan from rr_ptr upward (wrapping) and pick the first eligible requester.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr_reg) + k) % NREQ);
      if (!grant && eligible[cand]) begin
        grant    = 1'b1;
        grant_id = cand;
      end
    end
    if (clr) begin
      grant    = 1'b0;
      grant_id = '0;
    end
  end

  assign grant_op = grant & bus.req_op[grant_id];

`ifdef LIFO_ARB_ERR_EN
  // A granted request the stack cannot serve becomes an error response.
  assign grant_err = grant & (grant_op ? bus.lifo_full : bus.lifo_empty);
`else
  assign grant_err = 1'b0;
`endif

  assign do_push = grant &  grant_op & ~grant_err;
  assign do_pop  = grant & ~grant_op & ~grant_err;

  assign bus.req_ready = ready_vec;
  assign bus.lifo_push = do_push;
  assign bus.lifo_pop  = do_pop;
  assign bus.lifo_din  = do_push ? wdata_arr[grant_id] : '0;

  // Priority moves to the requester just after the winner; holds when idle.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant) begin
      if (grant_id == ID_W'(NREQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = grant_id + 1'b1;
      end
    end
  end

  // Priority pointer and response registers; clr clears them with the stack.
  always_ff @(posedge clk) begin
    if (clr) begin
      rr_ptr_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_op_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      rsp_valid_reg <= grant;
      rsp_id_reg    <= grant_id;
      rsp_op_reg    <= grant_op;
      rsp_err_reg   <= grant_err;
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_op    = rsp_op_reg;
  assign bus.rsp_err   = rsp_err_reg;
  // Pop data comes straight from the stack's freshly registered output.
  assign bus.rsp_data  = (rsp_valid_reg & ~rsp_op_reg & ~rsp_err_reg) ? bus.lifo_dout : '0;
endmodule

// File: tb/tb_lifo_rr_arbiter.sv
// tb_lifo_rr_arbiter: directed scenarios plus randomized traffic, checked
// each cycle against a queue-based model of arbiter + depth-4 stack.
module tb_lifo_rr_arbiter;
  localparam int DW    = 8;
  localparam int NR    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  lifo_rr_arbiter_if #(.DATA_WIDTH(DW), .NREQ(NR)) bus ();

  lifo_rr_arbiter #(.DATA_WIDTH(DW), .NREQ(NR)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------- stack instance (registered data_out) ----------------
  logic [DW-1:0] stk [DEPTH];
  logic [2:0]    cnt;
  logic [DW-1:0] dout_r;
  always @(posedge clk) begin
    if (clr) begin
      cnt    <= 3'd0;
      dout_r <= '0;
    end else if (bus.lifo_push && cnt < 3'd4) begin
      stk[cnt[1:0]] <= bus.lifo_din;
      cnt           <= cnt + 3'd1;
    end else if (bus.lifo_pop && cnt > 3'd0) begin
      dout_r <= stk[cnt[1:0] - 2'd1];
      cnt    <= cnt - 3'd1;
    end
  end
  assign bus.lifo_dout  = dout_r;
  assign bus.lifo_full  = (cnt == 3'd4);
  assign bus.lifo_empty = (cnt == 3'd0);

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  int            m_ptr = 0;
  logic [DW-1:0] m_q[$];
  logic          m_rsp_valid = 1'b0;
  int            m_rsp_id = 0;
  logic          m_rsp_op = 1'b0;
  logic          m_rsp_err = 1'b0;
  logic [DW-1:0] m_rsp_data = '0;
  logic          started = 1'b0;

  // decisions captured at the compare point, applied at the next edge
  logic          p_clr = 1'b1;
  int            p_g = -1;
  logic          p_op = 1'b0;
  logic          p_err = 1'b0;
  logic [DW-1:0] p_wd = '0;

  // Compare process: derive what this cycle must look like, check every output.
  always @(negedge clk) begin
    int            g;
    logic          ok;
    logic          err;
    logic [NR-1:0] e_ready;
    logic          e_push;
    logic          e_pop;
    logic [DW-1:0] e_din;
    logic [DW-1:0] wd;
    g = -1; err = 1'b0; e_ready = '0; e_push = 1'b0; e_pop = 1'b0; e_din = '0; wd = '0;
    if (!clr) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (g < 0 && bus.req_valid[i]) begin
          ok = bus.req_op[i] ? (m_q.size() < DEPTH) : (m_q.size() > 0);
`ifdef LIFO_ARB_ERR_EN
          g = i; err = !ok;
`else
          if (ok) g = i;
`endif
        end
      end
    end
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      wd     = bus.req_wdata[g*DW +: DW];
      e_push = bus.req_op[g] && !err;
      e_pop  = !bus.req_op[g] && !err;
      e_din  = e_push ? wd : '0;
    end
    if (started) begin
      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      chk("lifo_push", 32'(bus.lifo_push), 32'(e_push));
      chk("lifo_pop",  32'(bus.lifo_pop),  32'(e_pop));
      chk("lifo_din",  32'(bus.lifo_din),  32'(e_din));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_rsp_id));
        chk("rsp_op", 32'(bus.rsp_op), 32'(m_rsp_op));
      end
      chk("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
      chk("rsp_err",  32'(bus.rsp_err),  32'(m_rsp_err));
    end
    p_clr = clr;
    p_g   = g;
    p_op  = (g >= 0) ? bus.req_op[g] : 1'b0;
    p_err = err;
    p_wd  = wd;
  end

  // Model state advance at the clock edge.
  always @(posedge clk) begin
    started = 1'b1;
    if (p_clr) begin
      m_ptr = 0;
      m_q.delete();
      m_rsp_valid = 1'b0; m_rsp_id = 0; m_rsp_op = 1'b0; m_rsp_err = 1'b0; m_rsp_data = '0;
    end else begin
      m_rsp_valid = (p_g >= 0);
      m_rsp_id    = (p_g >= 0) ? p_g : 0;
      m_rsp_op    = p_op;
      m_rsp_err   = p_err;
      m_rsp_data  = '0;
      if (p_g >= 0) begin
        m_ptr = (p_g + 1) % NR;
        if (!p_err) begin
          if (p_op) m_q.push_back(p_wd);
          else      m_rsp_data = m_q.pop_back();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic c, input logic [1:0] v, input logic [1:0] o,
                     input logic [15:0] w);
    @(posedge clk);
    #1;
    clr           = c;
    bus.req_valid = v;
    bus.req_op    = o;
    bus.req_wdata = w;
    @(negedge clk);
  endtask

  logic [1:0] fair_exp [6];

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_wdata = '0;
    fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01; fair_exp[3] = 2'b10;
`ifdef LIFO_ARB_ERR_EN
    fair_exp[4] = 2'b01; fair_exp[5] = 2'b10;
`else
    fair_exp[4] = 2'b00; fair_exp[5] = 2'b00;
`endif

    // reset, then first request from requester 1
    cyc(1'b1, 2'b00, 2'b00, 16'h0);
    cyc(1'b1, 2'b00, 2'b00, 16'h0);
    cyc(1'b0, 2'b00, 2'b00, 16'h0);
    chk("lit_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lit_rst_ready",     32'(bus.req_ready), 32'd0);
    cyc(1'b0, 2'b10, 2'b10, 16'h1100);
    chk("lit_first_ready", 32'(bus.req_ready), 32'd2);
    chk("lit_first_din",   32'(bus.lifo_din),  32'h11);
    cyc(1'b0, 2'b00, 2'b00, 16'h0);
    chk("lit_first_rsp_id", 32'(bus.rsp_id), 32'd1);
    chk("lit_first_rsp_op", 32'(bus.rsp_op), 32'd1);

    // back-to-back pushes then pops from requester 0
    cyc(1'b0, 2'b01, 2'b01, 16'h00A1);
    cyc(1'b0, 2'b01, 2'b01, 16'h00A2);
    cyc(1'b0, 2'b01, 2'b01, 16'h00A3);
    cyc(1'b0, 2'b01, 2'b00, 16'h0);
    chk("lit_pop1_pop", 32'(bus.lifo_pop), 32'd1);
    cyc(1'b0, 2'b01, 2'b00, 16'h0);
    chk("lit_pop_a3", 32'(bus.rsp_data), 32'hA3);
    cyc(1'b0, 2'b01, 2'b00, 16'h0);
    chk("lit_pop_a2", 32'(bus.rsp_data), 32'hA2);
    cyc(1'b0, 2'b01, 2'b00, 16'h0);
    chk("lit_pop_a1", 32'(bus.rsp_data), 32'hA1);
    cyc(1'b0, 2'b00, 2'b00, 16'h0);
    chk("lit_pop_11", 32'(bus.rsp_data), 32'h11);

    // fairness: both push from reset until full
    cyc(1'b1, 2'b11, 2'b11, 16'h2010);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 2'b11, 2'b11, 16'h2010);
      chk($sformatf("lit_fair_%0d", k), 32'(bus.req_ready), 32'(fair_exp[k]));
    end

    // full gating: req0 pushes, req1 pops, stack full
    cyc(1'b0, 2'b11, 2'b01, 16'h0033);
`ifdef LIFO_ARB_ERR_EN
    chk("lit_gate_a", 32'(bus.req_ready), 32'd1);
    chk("lit_gate_a_push", 32'(bus.lifo_push), 32'd0);
`else
    chk("lit_gate_a", 32'(bus.req_ready), 32'd2);
`endif
    cyc(1'b0, 2'b11, 2'b01, 16'h0033);
`ifdef LIFO_ARB_ERR_EN
    chk("lit_gate_b", 32'(bus.req_ready), 32'd2);
`else
    chk("lit_gate_b", 32'(bus.req_ready), 32'd1);
    chk("lit_gate_b_din", 32'(bus.lifo_din), 32'h33);
`endif
    cyc(1'b0, 2'b00, 2'b00, 16'h0);

    // pop on empty
    cyc(1'b1, 2'b00, 2'b00, 16'h0);
    cyc(1'b0, 2'b10, 2'b00, 16'h0);
    chk("lit_empty_pop_op", 32'(bus.lifo_pop), 32'd0);
`ifdef LIFO_ARB_ERR_EN
    chk("lit_empty_ready", 32'(bus.req_ready), 32'd2);
`else
    chk("lit_empty_ready", 32'(bus.req_ready), 32'd0);
`endif
    cyc(1'b0, 2'b10, 2'b00, 16'h0);
`ifdef LIFO_ARB_ERR_EN
    chk("lit_err_rsp", 32'(bus.rsp_err), 32'd1);
    chk("lit_err_data", 32'(bus.rsp_data), 32'd0);
`else
    chk("lit_empty_ready2", 32'(bus.req_ready), 32'd0);
    chk("lit_empty_rsp", 32'(bus.rsp_valid), 32'd0);
`endif
    cyc(1'b0, 2'b00, 2'b00, 16'h0);

    // clr the cycle after a pop grant
    cyc(1'b0, 2'b01, 2'b01, 16'h0055);
    cyc(1'b0, 2'b01, 2'b01, 16'h0066);
    cyc(1'b0, 2'b01, 2'b00, 16'h0);
    cyc(1'b1, 2'b00, 2'b00, 16'h0);
    chk("lit_clr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("lit_clr_rsp_data",  32'(bus.rsp_data),  32'h66);
    cyc(1'b0, 2'b11, 2'b11, 16'h7877);
    chk("lit_post_clr_valid", 32'(bus.rsp_valid),  32'd0);
    chk("lit_post_clr_empty", 32'(bus.lifo_empty), 32'd1);
    chk("lit_post_clr_ptr",   32'(bus.req_ready),  32'd1);

    // randomized traffic with occasional clr
    for (int n = 0; n < 3000; n++) begin
      logic rc;
      rc = ($urandom_range(0, 99) == 0);
      cyc(rc, 2'($urandom), 2'($urandom), 16'($urandom));
    end
    cyc(1'b0, 2'b00, 2'b00, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
